// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_if;
    logic              stall_mem;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_we, mem_wdata, stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_we, mem_wdata, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for IF and MEM stages: data-priority grant, 1-cycle read return.
// Define ARB_FAIRNESS_EN to add the fetch starvation guard (MAX_DATA_STREAK).
module mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D} state_e;

    state_e state_q, state_d;
    logic   if_gnt, d_gnt, fair_fire;

    if (MAX_DATA_STREAK < 1 || MAX_DATA_STREAK > 15) begin : g_bad_streak
        $error("MAX_DATA_STREAK must be in 1..15");
    end

`ifdef ARB_FAIRNESS_EN
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    logic [3:0] streak_q, streak_d;

    // Counts data grants that fetch sat through; a waiting fetch wins once it saturates.
    assign fair_fire = bus.if_req & bus.d_req & (streak_q == STREAK_MAX);

    always_comb begin
        streak_d = streak_q;
        if (!bus.if_req || if_gnt)
            streak_d = '0;
        else if (d_gnt && streak_q != STREAK_MAX)
            streak_d = streak_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) streak_q <= '0;
        else      streak_q <= streak_d;
    end
`else
    assign fair_fire = 1'b0;
`endif

    // Grants are gated by rst so nothing reaches the memory while reset is held.
    always_comb begin
        d_gnt  = rst & bus.d_req & ~fair_fire;
        if_gnt = rst & bus.if_req & ~d_gnt;
    end

    assign bus.d_gnt     = d_gnt;
    assign bus.if_gnt    = if_gnt;
    assign bus.stall_if  = rst & bus.if_req & ~if_gnt;
    assign bus.stall_mem = rst & bus.d_req & ~d_gnt;
    assign bus.mem_we    = d_gnt & bus.d_we;
    assign bus.mem_addr  = d_gnt ? bus.d_addr : (if_gnt ? bus.if_addr : '0);
    assign bus.mem_wdata = d_gnt ? bus.d_wdata : '0;

    always_comb begin
        state_d = IDLE;
        if (if_gnt)
            state_d = RESP_IF;
        else if (d_gnt && !bus.d_we)
            state_d = RESP_D;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = '0;
        case (state_q)
            RESP_IF: begin
                bus.if_rvalid = 1'b1;
                bus.if_rdata  = bus.mem_rdata;
            end
            RESP_D: begin
                bus.d_rvalid = 1'b1;
                bus.d_rdata  = bus.mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected read responses are queued at grant
// time and popped when the response cycle comes around. Honors ARB_FAIRNESS_EN.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    typedef struct {
        logic        is_if;
        logic [31:0] data;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] mem[256];

    mem_port_arbiter_if bus();

    mem_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory: write at posedge, read data valid the next cycle.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hA5A5_0000 | {22'd0, a[9:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One cycle: check the response owed from the previous grant, then this cycle's grant.
    // erd is the read word for a load/fetch grant, or the expected mem_wdata for a store.
    task automatic step(input logic eig, input logic edg, input logic [31:0] eaddr,
                        input logic ewe, input logic [31:0] erd);
        resp_t e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("if_rvalid", {31'd0, bus.if_rvalid}, {31'd0, e.is_if});
            check("d_rvalid", {31'd0, bus.d_rvalid}, {31'd0, !e.is_if});
            check("rdata", e.is_if ? bus.if_rdata : bus.d_rdata, e.data);
        end else begin
            check("if_rvalid_idle", {31'd0, bus.if_rvalid}, 32'd0);
            check("d_rvalid_idle", {31'd0, bus.d_rvalid}, 32'd0);
            check("rdata_idle", bus.if_rdata | bus.d_rdata, 32'd0);
        end
        check("if_gnt", {31'd0, bus.if_gnt}, {31'd0, eig});
        check("d_gnt", {31'd0, bus.d_gnt}, {31'd0, edg});
        check("stall_if", {31'd0, bus.stall_if}, {31'd0, bus.if_req & ~eig & rst});
        check("stall_mem", {31'd0, bus.stall_mem}, {31'd0, bus.d_req & ~edg & rst});
        check("mem_addr", bus.mem_addr, eaddr);
        check("mem_we", {31'd0, bus.mem_we}, {31'd0, edg & ewe});
        if (edg && ewe) check("mem_wdata", bus.mem_wdata, erd);
        if (eig) exp_q.push_back('{1'b1, erd});
        else if (edg && !ewe) exp_q.push_back('{1'b0, erd});
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic we, input logic [31:0] da, input logic [31:0] wd);
        bus.if_req  = ir;
        bus.if_addr = ia;
        bus.d_req   = dr;
        bus.d_we    = we;
        bus.d_addr  = da;
        bus.d_wdata = wd;
    endtask

    initial begin
        logic exp_if;
        for (int i = 0; i < 256; i++) mem[i] = pat(32'(i) << 2);
        mem[32'h100 >> 2] = 32'h2402_0005;

        // Reset held with both ports requesting: everything must stay quiet.
        drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h40, 32'h1234_5678);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Release: fetch alone is granted in the same cycle.
        rst = 1'b1;
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h100, 1'b0, 32'h2402_0005);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Collision: data wins, fetch follows next cycle overlapping the load response.
        drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h40, 32'h0);
        step(1'b0, 1'b1, 32'h40, 1'b0, pat(32'h40));
        drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h100, 1'b0, 32'h2402_0005);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Store then load back.
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF);
        step(1'b0, 1'b1, 32'h80, 1'b1, 32'hDEAD_BEEF);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
        step(1'b0, 1'b1, 32'h80, 1'b0, 32'hDEAD_BEEF);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Back-to-back alternating ports.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
        step(1'b0, 1'b1, 32'h44, 1'b0, pat(32'h44));
        drive(1'b1, 32'h108, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h108, 1'b0, pat(32'h108));
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h48, 32'h0);
        step(1'b0, 1'b1, 32'h48, 1'b0, pat(32'h48));
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Continuous contention for 20 cycles.
        drive(1'b1, 32'h104, 1'b1, 1'b0, 32'h200, 32'h0);
        for (int i = 0; i < 20; i++) begin
`ifdef ARB_FAIRNESS_EN
            exp_if = (i % 5) == 4;
`else
            exp_if = 1'b0;
`endif
            step(exp_if, !exp_if, exp_if ? 32'h104 : 32'h200, 1'b0,
                 exp_if ? pat(32'h104) : pat(32'h200));
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Reset asserted while a load response is in flight.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h50, 32'h0);
        @(negedge clk);
        check("rst_pre_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
        rst = 1'b0;
        #1;
        check("rst_d_gnt", {31'd0, bus.d_gnt}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_stall_mem", {31'd0, bus.stall_mem}, 32'd0);
        exp_q.delete();
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b1;
        drive(1'b1, 32'h10C, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 32'h10C, 1'b0, pat(32'h10C));
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
